cfg_shift_loader: RTL and testbench

- Upstream feeder for the CLB configuration shift chain.
- Accepts configuration bytes over a valid/ready stream and serialises them LSB-first onto shift_i.
- Generates shift_clk pulses and holds shift_en for exactly CHAIN_LEN bits.
- Returns the chain's previous contents, captured from shift_o, as readback bytes.

---
 rtl/cfg_shift_loader.sv | 155 +++++++++++++++
 tb/tb_cfg_shift_loader.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_shift_loader.sv
// Feeds the CLB configuration shift chain: takes bytes from a valid/ready stream,
// shifts them LSB-first with a generated shift_clk, and returns the old chain contents.
module cfg_shift_loader #(
  parameter int CHAIN_LEN = 38,
  parameter int DATA_W    = 8,
  parameter int HALF_DIV  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              shift_clk,
  output logic              shift_en,
  output logic              shift_i,
  input  logic              shift_o,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  output logic [2:0]        fsm_state
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DIV_W = 8;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(HALF_DIV - 1);

  // Handshake: a byte moves on every clk edge where in_valid and in_ready are both 1.
  // in_ready is only ever high in FETCH, so FETCH consumes on in_valid alone.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SETUP  = 3'd2,
    HIGH   = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  next_idx;
  logic [DIV_W-1:0]  div_cnt;
  logic [DATA_W-1:0] byte_buf;
  logic [DATA_W-1:0] rb_shift;
  logic              last_bit;
  logic              byte_end;
  logic              div_end;

  assign fsm_state = state;
  assign next_idx  = bit_idx + 1'b1;
  assign last_bit  = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign byte_end  = (bit_idx == IDX_W'(DATA_W - 1));
  assign div_end   = (div_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      shift_clk <= 1'b0;
      shift_en  <= 1'b0;
      shift_i   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rb_data   <= '0;
      rb_valid  <= 1'b0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      div_cnt   <= '0;
      byte_buf  <= '0;
      rb_shift  <= '0;
    end else begin
      done     <= 1'b0;
      rb_valid <= 1'b0;
      if (abort && state != IDLE) begin
        // Chain is left exactly as far as it got; only the strobes are dropped.
        state     <= IDLE;
        in_ready  <= 1'b0;
        shift_clk <= 1'b0;
        shift_en  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state    <= FETCH;
              busy     <= 1'b1;
              in_ready <= 1'b1;
              bit_cnt  <= '0;
              bit_idx  <= '0;
              rb_shift <= '0;
            end
          end
          FETCH: begin
            if (in_valid) begin
              byte_buf <= in_data;
              in_ready <= 1'b0;
              shift_en <= 1'b1;
              shift_i  <= in_data[0];
              bit_idx  <= '0;
              div_cnt  <= DIV_RELOAD;
              state    <= SETUP;
            end
          end
          SETUP: begin
            if (div_end) begin
              // Tail bit is captured just before the chain shifts it away.
              rb_shift[bit_idx] <= shift_o;
              shift_clk         <= 1'b1;
              div_cnt           <= DIV_RELOAD;
              state             <= HIGH;
            end else begin
              div_cnt <= div_cnt - 1'b1;
            end
          end
          HIGH: begin
            if (div_end) begin
              shift_clk <= 1'b0;
              bit_cnt   <= bit_cnt + 1'b1;
              bit_idx   <= next_idx;
              div_cnt   <= DIV_RELOAD;
              if (last_bit) begin
                rb_data  <= rb_shift;
                rb_valid <= 1'b1;
                rb_shift <= '0;
                state    <= FINISH;
              end else if (byte_end) begin
                rb_data  <= rb_shift;
                rb_valid <= 1'b1;
                rb_shift <= '0;
                in_ready <= 1'b1;
                state    <= FETCH;
              end else begin
                shift_i <= byte_buf[next_idx];
                state   <= SETUP;
              end
            end else begin
              div_cnt <= div_cnt - 1'b1;
            end
          end
          FINISH: begin
            done     <= 1'b1;
            busy     <= 1'b0;
            shift_en <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_shift_loader.sv
// Directed bench for cfg_shift_loader: a behavioural 38-bit chain on shift_o, with
// HALF_DIV=1 and HALF_DIV=3 instances sharing stimulus through a select line.
module tb_cfg_shift_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       sel = 1'b0;

  logic       rdy1, sclk1, sen1, si1, busy1, done1, rbv1;
  logic [7:0] rbd1;
  logic [2:0] st1;
  logic       rdy3, sclk3, sen3, si3, busy3, done3, rbv3;
  logic [7:0] rbd3;
  logic [2:0] st3;

  logic        m_rdy, m_sclk, m_sen, m_si, m_busy, m_done, m_rbv;
  logic [7:0]  m_rbd;
  logic [37:0] chain = '0;
  logic        shift_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign shift_o = chain[0];
  assign m_rdy   = sel ? rdy3  : rdy1;
  assign m_sclk  = sel ? sclk3 : sclk1;
  assign m_sen   = sel ? sen3  : sen1;
  assign m_si    = sel ? si3   : si1;
  assign m_busy  = sel ? busy3 : busy1;
  assign m_done  = sel ? done3 : done1;
  assign m_rbv   = sel ? rbv3  : rbv1;
  assign m_rbd   = sel ? rbd3  : rbd1;

  cfg_shift_loader #(.CHAIN_LEN(38), .DATA_W(8), .HALF_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort & ~sel),
    .in_data(in_data), .in_valid(in_valid & ~sel), .in_ready(rdy1),
    .shift_clk(sclk1), .shift_en(sen1), .shift_i(si1), .shift_o(shift_o),
    .busy(busy1), .done(done1), .rb_data(rbd1), .rb_valid(rbv1), .fsm_state(st1)
  );

  cfg_shift_loader #(.CHAIN_LEN(38), .DATA_W(8), .HALF_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel),
    .in_data(in_data), .in_valid(in_valid & sel), .in_ready(rdy3),
    .shift_clk(sclk3), .shift_en(sen3), .shift_i(si3), .shift_o(shift_o),
    .busy(busy3), .done(done3), .rb_data(rbd3), .rb_valid(rbv3), .fsm_state(st3)
  );

  // Monitor state: written only by the monitor process below.
  int          rises = 0;
  int          rb_cnt = 0;
  int          done_cnt = 0;
  int          done_bad = 0;
  int          tviol = 0;
  int          hi_run = 0;
  int          lo_run = 100;
  int          stab = 100;
  int          last_hi = 0;
  int          hd = 1;
  logic        prev_clk = 1'b0;
  logic        prev_i = 1'b0;
  logic        prev_busy = 1'b0;
  logic        bit_log[8192];
  logic [7:0]  rb_log[1024];
  logic        preload_seen = 1'b0;

  // Written only by tests.
  logic        preload_tgl = 1'b0;
  logic [37:0] preload_val = '0;
  int          stall_err = 0;
  logic [7:0]  bytes[5];
  logic [7:0]  exp_q[$];

  always begin
    @(posedge clk);
    #1;
    hd = sel ? 3 : 1;
    if (preload_tgl != preload_seen) begin
      chain = preload_val;
      preload_seen = preload_tgl;
    end
    if (!rst_n) begin
      prev_clk = 1'b0;
      lo_run = 100;
      hi_run = 0;
      stab = 100;
    end else begin
      if (m_sclk && !prev_clk) begin
        bit_log[rises] = m_si;
        rises++;
        if (lo_run < hd || stab < hd || m_si !== prev_i) tviol++;
        if (m_sen) chain = {m_si, chain[37:1]};
        hi_run = 1;
      end else if (m_sclk) begin
        hi_run++;
        if (m_si !== prev_i) tviol++;
      end else if (prev_clk) begin
        last_hi = hi_run;
        if (hi_run != hd) tviol++;
        lo_run = 1;
      end else begin
        lo_run++;
      end
      stab = (m_si === prev_i) ? stab + 1 : 1;
    end
    if (m_rbv) begin
      rb_log[rb_cnt] = m_rbd;
      rb_cnt++;
    end
    if (m_done) begin
      done_cnt++;
      if (m_busy || m_sen || !prev_busy) done_bad++;
    end
    prev_busy = m_busy;
    prev_i = m_si;
    prev_clk = m_sclk;
  end

  // Driver: one frame from bytes[], optional stall before byte stall_at,
  // optional abort after abort_at rises, optional stray start after restart_at rises.
  task automatic run_frame(input int stall_at, input int stall_len, input int abort_at,
                           input int restart_at, output int stalled, output bit timed_out);
    int idx, r0, d0, cyc;
    bit rdy, fin, aborting;
    idx = 0; stalled = 0; r0 = rises; d0 = done_cnt; cyc = 0;
    rdy = 0; fin = 0; aborting = 0; timed_out = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!fin) begin
      if (in_valid && rdy) idx++;
      start = 1'b0;
      if (aborting) begin
        abort = 1'b0;
        fin = 1;
      end else if (done_cnt != d0) begin
        fin = 1;
      end else if (cyc >= 3000) begin
        timed_out = 1;
        fin = 1;
      end else begin
        if (abort_at > 0 && rises - r0 >= abort_at) begin
          abort = 1'b1;
          aborting = 1;
        end
        if (restart_at > 0 && rises - r0 == restart_at) start = 1'b1;
        if (idx == stall_at && stalled < stall_len && (stalled > 0 || m_rdy)) begin
          in_valid = 1'b0;
          stalled++;
          if (!m_rdy || m_sclk || !m_sen) stall_err++;
        end else begin
          in_valid = (idx < 5);
          in_data = (idx < 5) ? bytes[idx] : 8'h00;
        end
        rdy = m_rdy;
        cyc++;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({sclk1, sen1, si1, rdy1, busy1, done1, rbv1, rbd1, st1} !== 18'h0) begin
      failures++;
      $display("FAIL reset_outs_hd1: got %0h expected 0", {sclk1, sen1, si1, rdy1, busy1, done1, rbv1, rbd1, st1});
    end
    checks++;
    if ({sclk3, sen3, si3, rdy3, busy3, done3, rbv3, rbd3, st3} !== 18'h0) begin
      failures++;
      $display("FAIL reset_outs_hd3: got %0h expected 0", {sclk3, sen3, si3, rdy3, busy3, done3, rbv3, rbd3, st3});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_load;
    int r0, d0, b0, st;
    bit to;
    logic [7:0] b;
    bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h15};
    r0 = rises; d0 = done_cnt; b0 = rb_cnt;
    run_frame(-1, 0, 0, 0, st, to);
    checks++;
    if (to) begin failures++; $display("FAIL basic_timeout: got timeout expected done"); end
    checks++;
    if (rises - r0 != 38) begin failures++; $display("FAIL basic_rises: got %0d expected 38", rises - r0); end
    for (int k = 0; k < 38; k++) begin
      b = bytes[k / 8];
      checks++;
      if (bit_log[r0 + k] !== b[k % 8]) begin
        failures++;
        $display("FAIL basic_bit%0d: got %b expected %b", k, bit_log[r0 + k], b[k % 8]);
      end
    end
    checks++;
    if (chain !== 38'h1500FF3CA5) begin failures++; $display("FAIL basic_chain: got %0h expected 1500ff3ca5", chain); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done: got %0d expected 1", done_cnt - d0); end
    checks++;
    if (done_bad != 0) begin failures++; $display("FAIL basic_done_busy: got %0d bad pulses expected 0", done_bad); end
    checks++;
    if (rb_cnt - b0 != 5) begin failures++; $display("FAIL basic_rb_count: got %0d expected 5", rb_cnt - b0); end
    repeat (3) @(negedge clk);
    checks++;
    if ({m_busy, m_sen, m_sclk, m_rdy} !== 4'b0000) begin
      failures++; $display("FAIL basic_idle_after: got %b expected 0000", {m_busy, m_sen, m_sclk, m_rdy});
    end
  endtask

  task automatic test_readback;
    int b0, st;
    bit to;
    logic [7:0] e;
    preload_val = 38'h2AAAAAAAAA;
    preload_tgl = ~preload_tgl;
    repeat (2) @(negedge clk);
    bytes = '{8'h01, 8'h80, 8'h7E, 8'hC3, 8'hFF};
    b0 = rb_cnt;
    run_frame(-1, 0, 0, 0, st, to);
    exp_q = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h2A};
    checks++;
    if (rb_cnt - b0 != 5) begin failures++; $display("FAIL rb_count: got %0d expected 5", rb_cnt - b0); end
    for (int k = 0; k < 5; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rb_log[b0 + k] !== e) begin
        failures++; $display("FAIL rb_byte%0d: got %h expected %h", k, rb_log[b0 + k], e);
      end
    end
  endtask

  task automatic test_stall;
    int r0, b0, st, se0;
    bit to;
    logic [7:0] b, e;
    se0 = stall_err;
    bytes = '{8'h96, 8'h0F, 8'h5A, 8'hE1, 8'h2C};
    r0 = rises; b0 = rb_cnt;
    run_frame(2, 20, 0, 0, st, to);
    checks++;
    if (st != 20) begin failures++; $display("FAIL stall_len: got %0d expected 20", st); end
    checks++;
    if (stall_err != se0) begin failures++; $display("FAIL stall_outputs: got %0d bad cycles expected 0", stall_err - se0); end
    checks++;
    if (to || rises - r0 != 38) begin failures++; $display("FAIL stall_rises: got %0d expected 38", rises - r0); end
    for (int k = 0; k < 38; k++) begin
      b = bytes[k / 8];
      checks++;
      if (bit_log[r0 + k] !== b[k % 8]) begin
        failures++; $display("FAIL stall_bit%0d: got %b expected %b", k, bit_log[r0 + k], b[k % 8]);
      end
    end
    // Old contents are the previous frame's bytes; 0xFF's top two bits never entered the chain.
    exp_q = '{8'h01, 8'h80, 8'h7E, 8'hC3, 8'h3F};
    for (int k = 0; k < 5; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rb_log[b0 + k] !== e) begin
        failures++; $display("FAIL stall_rb%0d: got %h expected %h", k, rb_log[b0 + k], e);
      end
    end
  endtask

  task automatic test_abort;
    int r0, d0, b0, st;
    bit to;
    bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h15};
    r0 = rises; d0 = done_cnt; b0 = rb_cnt;
    run_frame(-1, 0, 13, 0, st, to);
    checks++;
    if ({m_sen, m_busy, m_sclk, m_rdy} !== 4'b0000) begin
      failures++; $display("FAIL abort_outs: got %b expected 0000", {m_sen, m_busy, m_sclk, m_rdy});
    end
    repeat (20) @(negedge clk);
    checks++;
    if (rises - r0 != 13) begin failures++; $display("FAIL abort_rises: got %0d expected 13", rises - r0); end
    checks++;
    if (done_cnt != d0) begin failures++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt - d0); end
    checks++;
    if (rb_cnt - b0 != 1) begin failures++; $display("FAIL abort_rb: got %0d expected 1", rb_cnt - b0); end
    r0 = rises; d0 = done_cnt; b0 = rb_cnt;
    run_frame(-1, 0, 0, 0, st, to);
    checks++;
    if (to || rises - r0 != 38) begin failures++; $display("FAIL abort_rerun_rises: got %0d expected 38", rises - r0); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL abort_rerun_done: got %0d expected 1", done_cnt - d0); end
    checks++;
    if (chain !== 38'h1500FF3CA5) begin failures++; $display("FAIL abort_rerun_chain: got %0h expected 1500ff3ca5", chain); end
  endtask

  task automatic test_half_div;
    int r0, d0, st;
    bit to;
    logic [7:0] b;
    sel = 1'b1;
    repeat (2) @(negedge clk);
    bytes = '{8'h5A, 8'hC3, 8'h96, 8'h0F, 8'hF0};
    r0 = rises; d0 = done_cnt;
    run_frame(-1, 0, 0, 0, st, to);
    checks++;
    if (to || rises - r0 != 38) begin failures++; $display("FAIL hd3_rises: got %0d expected 38", rises - r0); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL hd3_done: got %0d expected 1", done_cnt - d0); end
    checks++;
    if (last_hi != 3) begin failures++; $display("FAIL hd3_high_len: got %0d expected 3", last_hi); end
    checks++;
    if (tviol != 0) begin failures++; $display("FAIL hd3_timing: got %0d violations expected 0", tviol); end
    for (int k = 0; k < 38; k += 5) begin
      b = bytes[k / 8];
      checks++;
      if (bit_log[r0 + k] !== b[k % 8]) begin
        failures++; $display("FAIL hd3_bit%0d: got %b expected %b", k, bit_log[r0 + k], b[k % 8]);
      end
    end
    sel = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset;
    int r0, d0, n, st;
    bit to;
    r0 = rises;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; in_data = 8'hFF; in_valid = 1'b1;
    n = 0;
    while (rises - r0 < 5 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (m_busy !== 1'b1) begin failures++; $display("FAIL areset_midframe: got busy=%b expected 1", m_busy); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sclk1, sen1, si1, rdy1, busy1, done1, rbv1, rbd1, st1} !== 18'h0) begin
      failures++; $display("FAIL areset_outs: got %0h expected 0", {sclk1, sen1, si1, rdy1, busy1, done1, rbv1, rbd1, st1});
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    r0 = rises; d0 = done_cnt;
    run_frame(-1, 0, 0, 10, st, to);
    checks++;
    if (to || rises - r0 != 38) begin failures++; $display("FAIL busy_start_rises: got %0d expected 38", rises - r0); end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || m_busy !== 1'b0 || m_rdy !== 1'b0) begin
      failures++; $display("FAIL busy_start_ignored: got done=%0d busy=%b expected done=1 busy=0", done_cnt - d0, m_busy);
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({m_busy, m_rdy, st1} !== 5'b0) begin
      failures++; $display("FAIL start_abort_idle: got %b expected 00000", {m_busy, m_rdy, st1});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({m_busy, m_rdy, m_sen} !== 3'b000) begin
      failures++; $display("FAIL start_abort_stays: got %b expected 000", {m_busy, m_rdy, m_sen});
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_readback();
    test_stall();
    test_abort();
    test_half_div();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
